// File: rtl/vector_operand_packer_if.sv
// Element-serial input and packed-word output handshake of the vector operand packer.
// slave is the packer's view, master the producer/consumer side.
interface vector_operand_packer_if #(
  parameter int C_OP_WIDTH     = 16,
  parameter int C_NUM_OPERANDS = 2
);
  localparam int C_NUM_ELEM   = C_NUM_OPERANDS / 2;
  localparam int C_DOUT_WIDTH = C_OP_WIDTH * C_NUM_OPERANDS;
  localparam int C_CNT_WIDTH  = (C_NUM_ELEM > 1) ? $clog2(C_NUM_ELEM) : 1;

  logic [C_OP_WIDTH-1:0]   elem_a;
  logic [C_OP_WIDTH-1:0]   elem_b;
  logic                    elem_last;
  logic                    elem_valid;
  logic                    elem_ready;
  logic [C_DOUT_WIDTH-1:0] dout;
  logic                    dout_last;
  logic                    dout_valid;
  logic                    dout_ready;
  logic [C_CNT_WIDTH-1:0]  elem_idx;

  modport slave (
    input  elem_a, elem_b, elem_last, elem_valid, dout_ready,
    output elem_ready, dout, dout_last, dout_valid, elem_idx
  );

  modport master (
    output elem_a, elem_b, elem_last, elem_valid, dout_ready,
    input  elem_ready, dout, dout_last, dout_valid, elem_idx
  );
endinterface

// File: rtl/vector_operand_packer.sv
// Packs element-serial (a, b) pairs into {operand1 vector, operand0 vector} words
// behind a registered valid/ready output; elem_last zero-pads and flushes a partial vector.
module vector_operand_packer #(
  parameter int C_OP_WIDTH     = 16,
  parameter int C_NUM_OPERANDS = 2
) (
  input logic                    clk,
  input logic                    rst,
  vector_operand_packer_if.slave pk_if
);
  localparam int C_NUM_ELEM     = C_NUM_OPERANDS / 2;
  localparam int C_OP_VEC_WIDTH = C_OP_WIDTH * C_NUM_ELEM;
  localparam int C_DOUT_WIDTH   = C_OP_WIDTH * C_NUM_OPERANDS;
  localparam int C_CNT_WIDTH    = (C_NUM_ELEM > 1) ? $clog2(C_NUM_ELEM) : 1;
  localparam logic [C_CNT_WIDTH-1:0] C_LAST_LANE = C_CNT_WIDTH'(C_NUM_ELEM - 1);

  logic [C_OP_VEC_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [C_OP_VEC_WIDTH-1:0] a_fill, b_fill;
  logic [C_CNT_WIDTH-1:0]    idx_q, idx_d;
  logic [C_DOUT_WIDTH-1:0]   dout_q, dout_d;
  logic                      last_q, last_d;
  logic                      valid_q, valid_d;
  logic                      ready;
  logic                      accept;
  logic                      emit;

  assign ready  = !valid_q || pk_if.dout_ready;
  assign accept = pk_if.elem_valid && ready;
  assign emit   = accept && ((idx_q == C_LAST_LANE) || pk_if.elem_last);

  // Lanes above the current index are already zero because A/B clear on every emit.
  always_comb begin
    a_fill = a_q;
    b_fill = b_q;
    for (int i = 0; i < C_NUM_ELEM; i++) begin
      if (idx_q == C_CNT_WIDTH'(i)) begin
        a_fill[i*C_OP_WIDTH +: C_OP_WIDTH] = pk_if.elem_a;
        b_fill[i*C_OP_WIDTH +: C_OP_WIDTH] = pk_if.elem_b;
      end
    end
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (valid_q && pk_if.dout_ready) begin
      valid_d = 1'b0;
    end
    if (emit) begin
      dout_d  = {b_fill, a_fill};
      last_d  = pk_if.elem_last;
      valid_d = 1'b1;
      a_d     = '0;
      b_d     = '0;
      idx_d   = '0;
    end else if (accept) begin
      a_d   = a_fill;
      b_d   = b_fill;
      idx_d = idx_q + C_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      dout_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign pk_if.elem_ready = ready;
  assign pk_if.dout       = dout_q;
  assign pk_if.dout_last  = last_q;
  assign pk_if.dout_valid = valid_q;
  assign pk_if.elem_idx   = idx_q;
endmodule

// File: tb/tb_vector_operand_packer.sv
// Directed bench for vector_operand_packer with a 2-lane (4 operand) and a 4-lane (8 operand) instance.
module tb_vector_operand_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;
  int   words;
  logic [127:0] exp_w;

  vector_operand_packer_if #(.C_OP_WIDTH(16), .C_NUM_OPERANDS(4)) if4 ();
  vector_operand_packer_if #(.C_OP_WIDTH(16), .C_NUM_OPERANDS(8)) if8 ();

  vector_operand_packer #(.C_OP_WIDTH(16), .C_NUM_OPERANDS(4)) u_dut4 (
    .clk(clk), .rst(rst), .pk_if(if4)
  );
  vector_operand_packer #(.C_OP_WIDTH(16), .C_NUM_OPERANDS(8)) u_dut8 (
    .clk(clk), .rst(rst), .pk_if(if8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv4(input logic [15:0] a, input logic [15:0] b, input logic last, input logic vld);
    if4.elem_a     = a;
    if4.elem_b     = b;
    if4.elem_last  = last;
    if4.elem_valid = vld;
  endtask

  task automatic drv8(input logic [15:0] a, input logic [15:0] b, input logic last, input logic vld);
    if8.elem_a     = a;
    if8.elem_b     = b;
    if8.elem_last  = last;
    if8.elem_valid = vld;
  endtask

  initial begin
    drv4(16'h0, 16'h0, 1'b0, 1'b0);
    drv8(16'h0, 16'h0, 1'b0, 1'b0);
    if4.dout_ready = 1'b1;
    if8.dout_ready = 1'b1;
    #12 rst = 1'b0;
    tick();

    chk("rst_dout", if4.dout, 0);
    chk("rst_valid", if4.dout_valid, 0);
    chk("rst_last", if4.dout_last, 0);
    chk("rst_idx", if4.elem_idx, 0);
    chk("rst_ready", if4.elem_ready, 1);

    // element ordering
    drv4(16'h0001, 16'h0010, 1'b0, 1'b1);
    tick();
    chk("ord_idx1", if4.elem_idx, 1);
    chk("ord_nvalid", if4.dout_valid, 0);
    drv4(16'h0002, 16'h0020, 1'b0, 1'b1);
    tick();
    chk("ord_dout", if4.dout, 64'h0020_0010_0002_0001);
    chk("ord_valid", if4.dout_valid, 1);
    chk("ord_last", if4.dout_last, 0);
    chk("ord_idx0", if4.elem_idx, 0);
    drv4(16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    chk("ord_consumed", if4.dout_valid, 0);
    chk("ord_hold", if4.dout, 64'h0020_0010_0002_0001);

    // partial flush
    drv4(16'h1234, 16'hABCD, 1'b1, 1'b1);
    tick();
    chk("flush_dout", if4.dout, 64'h0000_ABCD_0000_1234);
    chk("flush_last", if4.dout_last, 1);
    chk("flush_valid", if4.dout_valid, 1);
    chk("flush_idx", if4.elem_idx, 0);
    drv4(16'h0, 16'h0, 1'b0, 1'b0);
    tick();

    // backpressure
    if4.dout_ready = 1'b0;
    drv4(16'h0011, 16'h0021, 1'b0, 1'b1);
    tick();
    drv4(16'h0012, 16'h0022, 1'b0, 1'b1);
    tick();
    chk("bp_word", if4.dout, 64'h0022_0021_0012_0011);
    drv4(16'h0013, 16'h0023, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", if4.elem_ready, 0);
      tick();
      chk("bp_stable", if4.dout, 64'h0022_0021_0012_0011);
      chk("bp_valid", if4.dout_valid, 1);
      chk("bp_idx", if4.elem_idx, 0);
    end
    if4.dout_ready = 1'b1;
    #1;
    chk("bp_release", if4.elem_ready, 1);
    tick();
    chk("bp_consumed", if4.dout_valid, 0);
    chk("bp_resume_idx", if4.elem_idx, 1);
    drv4(16'h0014, 16'h0024, 1'b0, 1'b1);
    tick();
    chk("bp_next_word", if4.dout, 64'h0024_0023_0014_0013);
    drv4(16'h0, 16'h0, 1'b0, 1'b0);
    tick();

    // streaming, 4 lanes
    words = 0;
    for (int i = 1; i <= 12; i++) begin
      drv8(16'(i), 16'(16'h0100 + i), 1'b0, 1'b1);
      #1;
      chk("strm_ready", if8.elem_ready, 1);
      tick();
      if (if8.dout_valid) words++;
      if (i % 4 == 0) begin
        exp_w = '0;
        for (int j = 0; j < 4; j++) begin
          exp_w[j*16 +: 16]      = 16'(i - 3 + j);
          exp_w[64 + j*16 +: 16] = 16'(16'h0100 + i - 3 + j);
        end
        chk("strm_valid", if8.dout_valid, 1);
        chk("strm_word", if8.dout, exp_w);
        if (i == 8) chk("strm_w2_lo", if8.dout[63:0], 64'h0008_0007_0006_0005);
      end else begin
        chk("strm_nvalid", if8.dout_valid, 0);
      end
    end
    drv8(16'h0, 16'h0, 1'b0, 1'b0);
    chk("strm_words", words, 3);
    tick();

    // reset mid-vector: DUT4 holds an unconsumed word, DUT8 is two lanes in
    if4.dout_ready = 1'b0;
    drv4(16'h0051, 16'h0061, 1'b0, 1'b1);
    drv8(16'h00A1, 16'h00B1, 1'b0, 1'b1);
    tick();
    drv4(16'h0052, 16'h0062, 1'b0, 1'b1);
    drv8(16'h00A2, 16'h00B2, 1'b0, 1'b1);
    tick();
    drv4(16'h0, 16'h0, 1'b0, 1'b0);
    drv8(16'h0, 16'h0, 1'b0, 1'b0);
    chk("mid_pre_valid", if4.dout_valid, 1);
    chk("mid_pre_dout", if4.dout, 64'h0062_0061_0052_0051);
    chk("mid_pre_idx", if8.elem_idx, 2);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_valid", if4.dout_valid, 0);
    chk("mid_rst_dout", if4.dout, 0);
    chk("mid_rst_idx", if8.elem_idx, 0);
    chk("mid_rst_ready", if4.elem_ready, 1);
    #1 rst = 1'b0;
    if4.dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drv8(16'(16'h0031 + i), 16'(16'h0041 + i), 1'b0, 1'b1);
      tick();
    end
    drv8(16'h0, 16'h0, 1'b0, 1'b0);
    chk("mid_new_valid", if8.dout_valid, 1);
    chk("mid_new_word", if8.dout, 128'h0044_0043_0042_0041_0034_0033_0032_0031);
    tick();

    // simultaneous consume and emit
    words = 0;
    drv4(16'h0101, 16'h0201, 1'b0, 1'b1);
    tick();
    chk("ce_e1_valid", if4.dout_valid, 0);
    drv4(16'h0102, 16'h0202, 1'b0, 1'b1);
    tick();
    if (if4.dout_valid) words++;
    chk("ce_w1", if4.dout, 64'h0202_0201_0102_0101);
    chk("ce_w1_last", if4.dout_last, 0);
    drv4(16'h0103, 16'h0203, 1'b1, 1'b1);
    tick();
    if (if4.dout_valid) words++;
    chk("ce_w2_valid", if4.dout_valid, 1);
    chk("ce_w2", if4.dout, 64'h0000_0203_0000_0103);
    chk("ce_w2_last", if4.dout_last, 1);
    drv4(16'h0104, 16'h0204, 1'b1, 1'b1);
    tick();
    if (if4.dout_valid) words++;
    chk("ce_w3_valid", if4.dout_valid, 1);
    chk("ce_w3", if4.dout, 64'h0000_0204_0000_0104);
    drv4(16'h0105, 16'h0205, 1'b0, 1'b1);
    tick();
    chk("ce_gap_valid", if4.dout_valid, 0);
    chk("ce_gap_idx", if4.elem_idx, 1);
    drv4(16'h0106, 16'h0206, 1'b1, 1'b1);
    tick();
    if (if4.dout_valid) words++;
    chk("ce_w4", if4.dout, 64'h0206_0205_0106_0105);
    chk("ce_w4_last", if4.dout_last, 1);
    drv4(16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    chk("ce_drained", if4.dout_valid, 0);
    chk("ce_words", words, 4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
